// File: rtl/data_cache_pkg.sv
// Shared geometry, controller state encoding and line-address helper for the
// data-cache hit/miss controller.
package data_cache_pkg;

  localparam int OFFSET_BITS         = 5;
  localparam int INDEX_BITS          = 8;
  localparam int TAG_BITS            = 19;
  localparam int ADDR_WIDTH          = 32;
  localparam int DATA_WIDTH          = 32;
  localparam int LOG2_WAYS           = 3;
  localparam int NUM_WAYS            = 8;
  localparam int CACHELINE_BIT_WIDTH = 256;
  localparam int BYTES_IN_CACHELINE  = 32;

  localparam int WORD_SEL_BITS = OFFSET_BITS - 2;
  localparam int WORD_LSB_BITS = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    FILL,
    REPLAY
  } CacheState;

  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [TAG_BITS-1:0]   tag,
    input logic [INDEX_BITS-1:0] index
  );
    return {tag, index, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/data_cache_way_match.sv
// Combinational tag compare across all ways; when several valid ways carry
// the same tag the lowest way index is reported.
module data_cache_way_match
  import data_cache_pkg::*;
(
  input  logic [TAG_BITS-1:0]                i_tag,
  input  logic [NUM_WAYS-1:0][TAG_BITS-1:0]  i_tagArray,
  input  logic [NUM_WAYS-1:0]                i_validArray,
  output logic                               o_hit,
  output logic [LOG2_WAYS-1:0]               o_hitWay
);

  logic [NUM_WAYS-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      w_match[i] = i_validArray[i] && (i_tagArray[i] == i_tag);
    end
  end

  // Scanning downward lets the lowest matching way overwrite higher ones.
  always_comb begin
    o_hitWay = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) o_hitWay = LOG2_WAYS'(i);
    end
  end

  assign o_hit = |w_match;

endmodule

// File: rtl/data_cache_hit_miss_ctrl.sv
// Data-cache hit/miss controller: tag compare and hit service in COMPARE,
// then write-back, line fill and a replay bubble on a miss.
module data_cache_hit_miss_ctrl
  import data_cache_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [OFFSET_BITS-1:0]                       offset_in,
  input  logic [INDEX_BITS-1:0]                        index_in,
  input  logic [TAG_BITS-1:0]                          tag_in,
  input  logic [NUM_WAYS-1:0][TAG_BITS-1:0]            tag_array_in,
  input  logic [NUM_WAYS-1:0][CACHELINE_BIT_WIDTH-1:0] data_array_in,
  input  logic [NUM_WAYS-1:0]                          valid_array_in,
  input  logic [NUM_WAYS-1:0]                          dirty_array_in,
  input  logic [LOG2_WAYS-1:0]                         lru_in,
  input  logic [CACHELINE_BIT_WIDTH-1:0]               mem_wdata_line_in,
  input  logic [BYTES_IN_CACHELINE-1:0]                mem_wben_line_in,
  input  logic                                         mem_read_in,
  input  logic                                         mem_write_in,
  output logic [DATA_WIDTH-1:0]                        cpu_rdata,
  output logic                                         cpu_resp,
  output logic                                         stall,
  output logic [NUM_WAYS-1:0]                          way_we,
  output logic [BYTES_IN_CACHELINE-1:0]                way_wben,
  output logic [CACHELINE_BIT_WIDTH-1:0]               way_wdata,
  output logic [NUM_WAYS-1:0]                          meta_we,
  output logic [TAG_BITS-1:0]                          meta_tag,
  output logic                                         meta_valid,
  output logic                                         meta_dirty,
  output logic                                         lru_we,
  output logic [LOG2_WAYS-1:0]                         lru_way,
  output logic [ADDR_WIDTH-1:0]                        pmem_addr,
  output logic                                         pmem_read,
  output logic                                         pmem_write,
  output logic [CACHELINE_BIT_WIDTH-1:0]               pmem_wdata,
  input  logic [CACHELINE_BIT_WIDTH-1:0]               pmem_rdata,
  input  logic                                         pmem_resp
);

  CacheState                      r_state;
  logic [LOG2_WAYS-1:0]           r_victimWay;

  logic                           w_req;
  logic                           w_hit;
  logic [LOG2_WAYS-1:0]           w_hitWay;
  logic                           w_victimDirty;
  logic [WORD_SEL_BITS-1:0]       w_wordSel;
  logic [CACHELINE_BIT_WIDTH-1:0] w_hitLine;
  logic                           w_unusedByteOffset;

  data_cache_way_match u_wayMatch (
    .i_tag        (tag_in),
    .i_tagArray   (tag_array_in),
    .i_validArray (valid_array_in),
    .o_hit        (w_hit),
    .o_hitWay     (w_hitWay)
  );

  assign w_req              = mem_read_in | mem_write_in;
  assign w_victimDirty      = valid_array_in[lru_in] & dirty_array_in[lru_in];
  assign w_wordSel          = offset_in[OFFSET_BITS-1:2];
  assign w_unusedByteOffset = ^offset_in[1:0];
  assign w_hitLine          = data_array_in[w_hitWay];
  assign cpu_rdata          = w_hitLine[{w_wordSel, {WORD_LSB_BITS{1'b0}}} +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COMPARE;
      r_victimWay <= '0;
    end else begin
      case (r_state)
        COMPARE: begin
          if (w_req && !w_hit) begin
            r_victimWay <= lru_in;
            r_state     <= w_victimDirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) r_state <= FILL;
        FILL:      if (pmem_resp) r_state <= REPLAY;
        REPLAY:    r_state <= COMPARE;
        default:   r_state <= COMPARE;
      endcase
    end
  end

  // Strobes are held low throughout reset so an interrupted miss never
  // commits a partial line or leaves a memory request hanging.
  always_comb begin
    cpu_resp   = 1'b0;
    stall      = 1'b0;
    way_we     = '0;
    way_wben   = '0;
    way_wdata  = mem_wdata_line_in;
    meta_we    = '0;
    meta_tag   = '0;
    meta_valid = 1'b0;
    meta_dirty = 1'b0;
    lru_we     = 1'b0;
    lru_way    = '0;
    pmem_addr  = line_addr(tag_in, index_in);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_wdata = '0;
    if (!rst) begin
      case (r_state)
        COMPARE: begin
          if (w_req && w_hit) begin
            cpu_resp = 1'b1;
            lru_we   = 1'b1;
            lru_way  = w_hitWay;
            if (mem_write_in) begin
              way_we[w_hitWay]  = 1'b1;
              way_wben          = mem_wben_line_in;
              meta_we[w_hitWay] = 1'b1;
              meta_tag          = tag_in;
              meta_valid        = 1'b1;
              meta_dirty        = 1'b1;
            end
          end else if (w_req) begin
            stall = 1'b1;
          end
        end
        WRITEBACK: begin
          stall      = 1'b1;
          pmem_write = 1'b1;
          pmem_addr  = line_addr(tag_array_in[r_victimWay], index_in);
          pmem_wdata = data_array_in[r_victimWay];
        end
        FILL: begin
          stall     = 1'b1;
          pmem_read = 1'b1;
          if (pmem_resp) begin
            way_we[r_victimWay]  = 1'b1;
            way_wben             = '1;
            way_wdata            = pmem_rdata;
            meta_we[r_victimWay] = 1'b1;
            meta_tag             = tag_in;
            meta_valid           = 1'b1;
          end
        end
        REPLAY:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_hit_miss_ctrl.sv
// Bench for data_cache_hit_miss_ctrl: emulates the way BRAMs and a line memory,
// runs directed cases then random traffic checked against a flat memory model.
module tb_data_cache_hit_miss_ctrl;
  import data_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [OFFSET_BITS-1:0]                       offset_in;
  logic [INDEX_BITS-1:0]                        index_in;
  logic [TAG_BITS-1:0]                          tag_in;
  logic [NUM_WAYS-1:0][TAG_BITS-1:0]            tag_array_in;
  logic [NUM_WAYS-1:0][CACHELINE_BIT_WIDTH-1:0] data_array_in;
  logic [NUM_WAYS-1:0]                          valid_array_in;
  logic [NUM_WAYS-1:0]                          dirty_array_in;
  logic [LOG2_WAYS-1:0]                         lru_in;
  logic [CACHELINE_BIT_WIDTH-1:0]               mem_wdata_line_in;
  logic [BYTES_IN_CACHELINE-1:0]                mem_wben_line_in;
  logic                                         mem_read_in;
  logic                                         mem_write_in;
  logic [DATA_WIDTH-1:0]                        cpu_rdata;
  logic                                         cpu_resp;
  logic                                         stall;
  logic [NUM_WAYS-1:0]                          way_we;
  logic [BYTES_IN_CACHELINE-1:0]                way_wben;
  logic [CACHELINE_BIT_WIDTH-1:0]               way_wdata;
  logic [NUM_WAYS-1:0]                          meta_we;
  logic [TAG_BITS-1:0]                          meta_tag;
  logic                                         meta_valid;
  logic                                         meta_dirty;
  logic                                         lru_we;
  logic [LOG2_WAYS-1:0]                         lru_way;
  logic [ADDR_WIDTH-1:0]                        pmem_addr;
  logic                                         pmem_read;
  logic                                         pmem_write;
  logic [CACHELINE_BIT_WIDTH-1:0]               pmem_wdata;
  logic [CACHELINE_BIT_WIDTH-1:0]               pmem_rdata;
  logic                                         pmem_resp;

  always #5 clk = ~clk;

  data_cache_hit_miss_ctrl dut (
    .clk(clk), .rst(rst), .offset_in(offset_in), .index_in(index_in), .tag_in(tag_in),
    .tag_array_in(tag_array_in), .data_array_in(data_array_in),
    .valid_array_in(valid_array_in), .dirty_array_in(dirty_array_in), .lru_in(lru_in),
    .mem_wdata_line_in(mem_wdata_line_in), .mem_wben_line_in(mem_wben_line_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .cpu_rdata(cpu_rdata),
    .cpu_resp(cpu_resp), .stall(stall), .way_we(way_we), .way_wben(way_wben),
    .way_wdata(way_wdata), .meta_we(meta_we), .meta_tag(meta_tag), .meta_valid(meta_valid),
    .meta_dirty(meta_dirty), .lru_we(lru_we), .lru_way(lru_way), .pmem_addr(pmem_addr),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Way BRAM contents, presented for the currently latched index.
  logic [TAG_BITS-1:0]            tagMem   [0:255][0:7];
  logic                           validMem [0:255][0:7];
  logic                           dirtyMem [0:255][0:7];
  logic [CACHELINE_BIT_WIDTH-1:0] dataMem  [0:255][0:7];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : gBram
    assign tag_array_in[w]   = tagMem[index_in][w];
    assign valid_array_in[w] = validMem[index_in][w];
    assign dirty_array_in[w] = dirtyMem[index_in][w];
    assign data_array_in[w]  = dataMem[index_in][w];
  end

  logic [CACHELINE_BIT_WIDTH-1:0] lineMem [logic [31:0]];
  logic [CACHELINE_BIT_WIDTH-1:0] refLine [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int memLat = 1;
  int busy   = 0;

  logic                           cStall, cResp, cMetaValid, cMetaDirty, cLruWe, cPRead, cPWrite;
  logic [DATA_WIDTH-1:0]          cRdata;
  logic [NUM_WAYS-1:0]            cWayWe, cMetaWe;
  logic [BYTES_IN_CACHELINE-1:0]  cWben;
  logic [CACHELINE_BIT_WIDTH-1:0] cWdata, cPWdata;
  logic [TAG_BITS-1:0]            cMetaTag;
  logic [LOG2_WAYS-1:0]           cLruWay;
  logic [ADDR_WIDTH-1:0]          cPAddr;
  logic [INDEX_BITS-1:0]          cIdx;

  int                             nCycles, nStall, firstRd, lastWr;
  logic                           done, sawBoth, sawPmem, sawWrite, fillDirty, fillValid;
  logic [ADDR_WIDTH-1:0]          rdAddr, wrAddr;
  logic [CACHELINE_BIT_WIDTH-1:0] wrData;
  logic [NUM_WAYS-1:0]            fillWe, fillMetaWe;
  logic [BYTES_IN_CACHELINE-1:0]  fillWben;

  function automatic logic [CACHELINE_BIT_WIDTH-1:0] initLine(input logic [31:0] a);
    logic [CACHELINE_BIT_WIDTH-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a + 32'(k)) * 32'h9E3779B1;
    return l;
  endfunction

  function automatic logic [CACHELINE_BIT_WIDTH-1:0] readMem(input logic [31:0] a);
    return lineMem.exists(a) ? lineMem[a] : initLine(a);
  endfunction

  function automatic logic [CACHELINE_BIT_WIDTH-1:0] refGet(input logic [31:0] a);
    return refLine.exists(a) ? refLine[a] : initLine(a);
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [18:0] tag,
                               input logic [7:0] idx, input logic [4:0] off,
                               input logic [31:0] wben, input logic [255:0] wdata,
                               input logic [2:0] lru);
    mem_read_in       = rd;
    mem_write_in      = wr;
    tag_in            = tag;
    index_in          = idx;
    offset_in         = off;
    mem_wben_line_in  = wben;
    mem_wdata_line_in = wdata;
    lru_in            = lru;
  endtask

  // One clock: line memory answers at the negedge, outputs are captured,
  // then way/meta writes land in the BRAM arrays just after the posedge.
  task automatic stepCycle();
    @(negedge clk);
    if (pmem_read || pmem_write) begin
      busy++;
      if (busy >= memLat) begin
        pmem_resp = 1'b1;
        busy      = 0;
        if (pmem_write) lineMem[pmem_addr] = pmem_wdata;
        else pmem_rdata = readMem(pmem_addr);
      end else begin
        pmem_resp = 1'b0;
      end
    end else begin
      pmem_resp = 1'b0;
      busy      = 0;
    end
    #1;
    cStall = stall;     cResp = cpu_resp;      cRdata = cpu_rdata;
    cWayWe = way_we;    cWben = way_wben;      cWdata = way_wdata;
    cMetaWe = meta_we;  cMetaTag = meta_tag;   cMetaValid = meta_valid;
    cMetaDirty = meta_dirty;  cLruWe = lru_we; cLruWay = lru_way;
    cPRead = pmem_read; cPWrite = pmem_write;  cPAddr = pmem_addr;
    cPWdata = pmem_wdata;     cIdx = index_in;
    @(posedge clk);
    #1;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (cWayWe[w])
        for (int b = 0; b < BYTES_IN_CACHELINE; b++)
          if (cWben[b]) dataMem[cIdx][w][b*8 +: 8] = cWdata[b*8 +: 8];
      if (cMetaWe[w]) begin
        tagMem[cIdx][w]   = cMetaTag;
        validMem[cIdx][w] = cMetaValid;
        dirtyMem[cIdx][w] = cMetaDirty;
      end
    end
  endtask

  task automatic runRequest();
    done = 1'b0; nCycles = 0; nStall = 0; firstRd = -1; lastWr = -1;
    sawBoth = 1'b0; sawPmem = 1'b0; sawWrite = 1'b0;
    rdAddr = '0; wrAddr = '0; wrData = '0;
    fillWe = '0; fillMetaWe = '0; fillWben = '0; fillDirty = 1'b1; fillValid = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      stepCycle();
      nCycles++;
      if (cStall) nStall++;
      if (cPRead && cPWrite) sawBoth = 1'b1;
      if (cPRead || cPWrite) sawPmem = 1'b1;
      if (cPRead) begin
        rdAddr = cPAddr;
        if (firstRd < 0) firstRd = cyc;
      end
      if (cPWrite) begin
        sawWrite = 1'b1; wrAddr = cPAddr; wrData = cPWdata; lastWr = cyc;
      end
      if (cPRead && cWayWe != '0) begin
        fillWe = cWayWe; fillMetaWe = cMetaWe; fillWben = cWben;
        fillDirty = cMetaDirty; fillValid = cMetaValid;
      end
      if (cResp) done = 1'b1;
    end
    if (!done) checkOutput("req_timeout", done, 1'b1);
  endtask

  logic [CACHELINE_BIT_WIDTH-1:0] line, tmp, wdat;
  logic [31:0]                    addr, wben, expWord;
  logic [18:0]                    rTag;
  logic [7:0]                     rIdx;
  logic [4:0]                     rOff;
  int                             op;

  initial begin
    for (int s = 0; s < 256; s++)
      for (int w = 0; w < NUM_WAYS; w++) begin
        tagMem[s][w] = '0; validMem[s][w] = 1'b0; dirtyMem[s][w] = 1'b0; dataMem[s][w] = '0;
      end
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_resp", cpu_resp, 1'b0);
    checkOutput("rst_pmem", {pmem_read, pmem_write}, 2'b00);
    checkOutput("rst_strobes", {way_we, meta_we, lru_we}, '0);
    rst = 1'b0;

    // Idle with a stray pmem_resp: no movement
    pmem_resp = 1'b1;
    #1;
    checkOutput("idle_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    #1;
    checkOutput("idle_pmem", {pmem_read, pmem_write, cpu_resp}, 3'b000);

    // Load hit in way 3
    $display("[TB] load hit");
    tagMem[3][3] = 19'h00111; validMem[3][3] = 1'b1;
    line = initLine(32'h1111); line[95:64] = 32'hDEADBEEF; dataMem[3][3] = line;
    applyStimulus(1, 0, 19'h00111, 8'h03, 5'h08, '0, '0, 3'd0);
    runRequest();
    checkOutput("ldhit_cycles", nCycles, 1);
    checkOutput("ldhit_rdata", cRdata, 32'hDEADBEEF);
    checkOutput("ldhit_lru", {cLruWe, cLruWay}, {1'b1, 3'd3});
    checkOutput("ldhit_nopmem", sawPmem, 1'b0);
    checkOutput("ldhit_stall", nStall, 0);

    // Store hit in way 1, read and write both set
    $display("[TB] store hit");
    tagMem[4][1] = 19'h00222; validMem[4][1] = 1'b1;
    wdat = initLine(32'h2222);
    applyStimulus(1, 1, 19'h00222, 8'h04, 5'h00, 32'h0000000F, wdat, 3'd6);
    runRequest();
    checkOutput("sthit_cycles", nCycles, 1);
    checkOutput("sthit_waywe", cWayWe, 8'h02);
    checkOutput("sthit_wben", cWben, 32'h0000000F);
    checkOutput("sthit_wdata", cWdata, wdat);
    checkOutput("sthit_metawe", cMetaWe, 8'h02);
    checkOutput("sthit_meta", {cMetaTag, cMetaValid, cMetaDirty}, {19'h00222, 1'b1, 1'b1});

    // Clean miss, victim 5, fill answered on the fourth cycle
    $display("[TB] clean miss");
    memLat = 4;
    applyStimulus(1, 0, 19'h01234, 8'h07, 5'h04, '0, '0, 3'd5);
    runRequest();
    tmp = readMem(32'h024680E0);
    checkOutput("clean_addr", rdAddr, 32'h024680E0);
    checkOutput("clean_stall", nStall, 6);
    checkOutput("clean_nowb", sawWrite, 1'b0);
    checkOutput("clean_waywe", {fillWe, fillMetaWe}, {8'h20, 8'h20});
    checkOutput("clean_wben", fillWben, 32'hFFFFFFFF);
    checkOutput("clean_meta", {fillValid, fillDirty}, 2'b10);
    checkOutput("clean_rdata", cRdata, tmp[63:32]);
    checkOutput("clean_lru", cLruWay, 3'd5);

    // Dirty miss, victim way 2 holding tag 0x0AAAA
    $display("[TB] dirty miss");
    memLat = 3;
    line = initLine(32'h7777);
    tagMem[9][2] = 19'h0AAAA; validMem[9][2] = 1'b1; dirtyMem[9][2] = 1'b1; dataMem[9][2] = line;
    applyStimulus(1, 0, 19'h0BBBB, 8'h09, 5'h1C, '0, '0, 3'd2);
    runRequest();
    addr = {19'h0BBBB, 8'h09, 5'h00};
    tmp = initLine(addr);
    checkOutput("dirty_wbaddr", wrAddr, {19'h0AAAA, 8'h09, 5'h00});
    checkOutput("dirty_wbdata", wrData, line);
    checkOutput("dirty_order", (lastWr >= 0) && (firstRd > lastWr), 1'b1);
    checkOutput("dirty_noboth", sawBoth, 1'b0);
    checkOutput("dirty_rdaddr", rdAddr, addr);
    checkOutput("dirty_stall", nStall, 8);
    checkOutput("dirty_rdata", cRdata, tmp[255:224]);

    // Reset during FILL
    $display("[TB] reset mid-fill");
    memLat = 20;
    applyStimulus(1, 0, 19'h00444, 8'h0B, 5'h00, '0, '0, 3'd4);
    repeat (3) stepCycle();
    checkOutput("rstfill_active", cPRead, 1'b1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    mem_read_in = 1'b0;
    tmp = '0;
    tmp[7:0] = cWayWe;
    stepCycle();
    checkOutput("rstfill_pread", cPRead, 1'b0);
    checkOutput("rstfill_stall", cStall, 1'b0);
    checkOutput("rstfill_nowrite", {tmp[7:0], cWayWe, cMetaWe}, '0);
    checkOutput("rstfill_valid", validMem[8'h0B][4], 1'b0);

    // Duplicate tag in ways 2 and 6
    $display("[TB] duplicate tag");
    tagMem[13][2] = 19'h00333; validMem[13][2] = 1'b1; dataMem[13][2] = initLine(32'hA2);
    tagMem[13][6] = 19'h00333; validMem[13][6] = 1'b1; dataMem[13][6] = initLine(32'hA6);
    line = initLine(32'hA2);
    applyStimulus(1, 0, 19'h00333, 8'h0D, 5'h00, '0, '0, 3'd0);
    runRequest();
    checkOutput("dup_way", cLruWay, 3'd2);
    checkOutput("dup_rdata", cRdata, line[31:0]);

    // Random traffic over two sets with more tags than ways
    $display("[TB] random traffic");
    for (int n = 0; n < 120; n++) begin
      op   = $urandom_range(0, 2);
      rIdx = 8'h20 + 8'($urandom_range(0, 1));
      rTag = 19'($urandom_range(0, 11));
      rOff = 5'($urandom_range(0, 31));
      wben = $urandom;
      for (int k = 0; k < 8; k++) wdat[k*32 +: 32] = $urandom;
      memLat = $urandom_range(1, 4);
      addr = {rTag, rIdx, 5'h00};
      applyStimulus(op != 1, op != 0, rTag, rIdx, rOff, wben, wdat, 3'($urandom_range(0, 7)));
      runRequest();
      checkOutput("rand_noboth", sawBoth, 1'b0);
      tmp = refGet(addr);
      if (op == 0) begin
        expWord = tmp[rOff[4:2]*32 +: 32];
        checkOutput("rand_load", cRdata, expWord);
      end else begin
        for (int b = 0; b < 32; b++) if (wben[b]) tmp[b*8 +: 8] = wdat[b*8 +: 8];
        refLine[addr] = tmp;
      end
    end
    applyStimulus(0, 0, '0, '0, '0, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
